// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   Issue-stage hazard scheduler. Holds a per-register countdown of cycles
//   until each pending result is available (64 indices: x0-x31, f0-f31), a
//   write-port reservation vector, and a busy counter for the shared
//   fdiv/fsqrt unit. dec_ready drops on RAW, WAW, write-port or divider
//   conflicts. Issue outputs are registered one cycle after fire.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   dec_*               decoded instruction (valid/ready handshake)
//   iss_valid/class/rd  registered record of last cycle's issue
//   div_start           registered start pulse to the fdiv/fsqrt unit
//   wb_slot             a reserved write-back lands this cycle
//   stall_cnt           saturating count of dec_valid & !dec_ready cycles
module issue_scoreboard #(
  parameter int FP_LAT  = 4,
  parameter int DIV_LAT = 16,
  parameter int LD_LAT  = 2,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [5:0]  dec_rs1,
  input  logic [5:0]  dec_rs2,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic [5:0]  dec_rd,
  input  logic        dec_regwrite,
  input  logic [1:0]  dec_class,
  output logic        iss_valid,
  output logic [1:0]  iss_class,
  output logic [5:0]  iss_rd,
  output logic        div_start,
  output logic        wb_slot,
  output logic [31:0] stall_cnt
);
  localparam int NREG = 64;
  localparam int RW   = 2**CW;
  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_FPU = 2'd1;
  localparam logic [1:0] CLS_DIV = 2'd2;

  logic [NREG-1:0][CW-1:0] pend_q, pend_d;
  logic [RW-1:0]           rsv_q, rsv_d;
  logic [CW-1:0]           div_cnt_q, div_cnt_d;
  logic                    iss_valid_q, iss_valid_d;
  logic [1:0]              iss_class_q, iss_class_d;
  logic [5:0]              iss_rd_q, iss_rd_d;
  logic                    div_start_q, div_start_d;
  logic [31:0]             stall_cnt_q, stall_cnt_d;

  logic [CW-1:0] lat;
  logic          wr, raw, waw, port, unit, fire;

  always_comb begin
    case (dec_class)
      CLS_ALU: lat = CW'(1);
      CLS_FPU: lat = CW'(FP_LAT);
      CLS_DIV: lat = CW'(DIV_LAT);
      default: lat = CW'(LD_LAT);
    endcase
    wr   = dec_regwrite & (dec_rd != 6'd0);
    // A result due this cycle (pend==1) is forwarded, so only >1 blocks.
    raw  = (dec_use_rs1 & (pend_q[dec_rs1] > CW'(1))) |
           (dec_use_rs2 & (pend_q[dec_rs2] > CW'(1)));
    // Younger write must land strictly after any older write to rd.
    waw  = wr & (pend_q[dec_rd] >= lat);
    port = wr & rsv_q[lat];
    unit = (dec_class == CLS_DIV) & (div_cnt_q != '0);
    dec_ready = ~rst & ~(raw | waw | port | unit);
    fire = dec_valid & dec_ready;

    for (int i = 0; i < NREG; i++)
      pend_d[i] = (pend_q[i] != '0) ? pend_q[i] - CW'(1) : '0;
    if (fire & wr) pend_d[dec_rd] = lat;
    pend_d[0] = '0;

    rsv_d = rsv_q >> 1;
    if (fire & wr) rsv_d = rsv_d | (RW'(1) << (lat - CW'(1)));

    if (fire & (dec_class == CLS_DIV))
      div_cnt_d = CW'(DIV_LAT - 1);
    else
      div_cnt_d = (div_cnt_q != '0) ? div_cnt_q - CW'(1) : '0;

    iss_valid_d = fire;
    iss_class_d = fire ? dec_class : iss_class_q;
    iss_rd_d    = fire ? dec_rd : iss_rd_q;
    div_start_d = fire & (dec_class == CLS_DIV);

    stall_cnt_d = stall_cnt_q;
    if (dec_valid & ~dec_ready & (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      rsv_q       <= '0;
      div_cnt_q   <= '0;
      iss_valid_q <= 1'b0;
      iss_class_q <= '0;
      iss_rd_q    <= '0;
      div_start_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      rsv_q       <= rsv_d;
      div_cnt_q   <= div_cnt_d;
      iss_valid_q <= iss_valid_d;
      iss_class_q <= iss_class_d;
      iss_rd_q    <= iss_rd_d;
      div_start_q <= div_start_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_class = iss_class_q;
  assign iss_rd    = iss_rd_q;
  assign div_start = div_start_q;
  assign wb_slot   = rsv_q[0];
  assign stall_cnt = stall_cnt_q;
endmodule
